// File: rtl/sync_rr_arbiter_if.sv
// Request/grant bundle between N clk-domain requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface sync_rr_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           preempt;

    // 4-phase handshake: req[i] rises and stays high until gnt[i] is seen,
    // stays high for as long as the resource is in use, and falls to release it.
    // gnt[i] falls on the edge after req[i] is sampled low, or early on preemption.
    modport master (output req, input gnt, gnt_valid, gnt_id, preempt);
    modport slave  (input req, output gnt, gnt_valid, gnt_id, preempt);
endinterface

// File: rtl/sync_rr_arbiter.sv
// Clocked round-robin arbiter with registered one-hot grants, a one-cycle gap
// between owners, and an optional hold limit that preempts a long-running owner.
module sync_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 0,
    parameter int IDW      = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sync_rr_arbiter_if.slave     bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam int HCW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_MAX  = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);
    localparam logic [IDW:0]   N_W       = (IDW + 1)'(N);

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           preempt_q, preempt_d;
    logic           gnt_valid_q, gnt_valid_d;

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot_req;
    logic           win_found;
    logic [IDW-1:0] win_off;
    logic [IDW-1:0] win_id;
    logic           owner_req;
    logic           others_pending;
    logic           preempt_hit;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input logic [IDW-1:0] off);
        logic [IDW:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= N_W) sum = sum - N_W;
        return sum[IDW-1:0];
    endfunction

    // Rotating req so bit 0 is the ptr position turns the circular scan into a
    // plain lowest-set-bit search.
    assign req_dbl = {bus.req, bus.req} >> ptr_q;
    assign rot_req = req_dbl[N-1:0];

    always_comb begin
        win_found = 1'b0;
        win_off   = '0;
        for (int off = 0; off < N; off++) begin
            if (!win_found && rot_req[off]) begin
                win_found = 1'b1;
                win_off   = IDW'(off);
            end
        end
        win_id = wrap_add(ptr_q, win_off);
    end

    assign owner_req      = bus.req[gnt_id_q];
    assign others_pending = |(bus.req & ~gnt_q);
    assign preempt_hit    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && others_pending;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                gnt_d = '0;
                if (win_found) begin
                    gnt_d         = '0;
                    gnt_d[win_id] = 1'b1;
                    gnt_id_d      = win_id;
                    hold_cnt_d    = '0;
                    state_d       = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // An owner dropping req wins over a coincident preemption.
                if (!owner_req) begin
                    gnt_d   = '0;
                    ptr_d   = wrap_add(gnt_id_q, IDW'(1));
                    state_d = ST_RELEASE;
                end else if (preempt_hit) begin
                    gnt_d     = '0;
                    preempt_d = 1'b1;
                    ptr_d     = wrap_add(gnt_id_q, IDW'(1));
                    state_d   = ST_RELEASE;
                end else if (hold_cnt_q < HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        gnt_valid_d = |gnt_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            preempt_q   <= 1'b0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            preempt_q   <= preempt_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.preempt   = preempt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_sync_rr_arbiter.sv
// Bench for sync_rr_arbiter: a MAX_HOLD=4 instance and an unlimited-hold
// instance share the same request stimulus, checked cycle by cycle.
module tb_sync_rr_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int W   = 14;
    localparam logic [1:0] SI = 2'd0;
    localparam logic [1:0] SG = 2'd1;
    localparam logic [1:0] SR = 2'd2;

    typedef struct {
        logic         rst_n;
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [IDW-1:0] id;
        logic         pre;
        logic [1:0]   st;
        logic [N-1:0] gnt0;
    } vec_t;

    logic clk;
    logic rst_n;
    logic [1:0] st4;
    logic [1:0] st0;

    sync_rr_arbiter_if #(.N(N), .IDW(IDW)) if4 ();
    sync_rr_arbiter_if #(.N(N), .IDW(IDW)) if0 ();

    sync_rr_arbiter #(.N(N), .MAX_HOLD(4), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if4.slave),
        .dbg_state (st4)
    );

    sync_rr_arbiter #(.N(N), .MAX_HOLD(0), .IDW(IDW)) dut_nolimit (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if0.slave),
        .dbg_state (st0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vecs[$];
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic vd(input logic r, input logic [N-1:0] rq, input logic [N-1:0] g,
                      input logic [IDW-1:0] id, input logic pre, input logic [1:0] st,
                      input logic [N-1:0] g0);
        vec_t e;
        e.rst_n = r; e.req = rq; e.gnt = g; e.id = id; e.pre = pre; e.st = st; e.gnt0 = g0;
        vecs.push_back(e);
    endtask

    task automatic v(input logic r, input logic [N-1:0] rq, input logic [N-1:0] g,
                     input logic [IDW-1:0] id, input logic pre, input logic [1:0] st);
        vd(r, rq, g, id, pre, st, g);
    endtask

    task automatic do_reset();
        v(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, SI);
    endtask

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] o;
        o = '0;
        o[k] = 1'b1;
        return o;
    endfunction

    // driver: apply one vector at negedge, check just after the next posedge
    task automatic apply(input int idx, input vec_t e);
        logic [W-1:0] got;
        logic [W-1:0] exp;
        @(negedge clk);
        rst_n   = e.rst_n;
        if4.req = e.req;
        if0.req = e.req;
        exp_q.push_back({e.st, e.gnt0, e.gnt, |e.gnt, e.id, e.pre});
        @(posedge clk);
        #1;
        got = {st4, if0.gnt, if4.gnt, if4.gnt_valid, if4.gnt_id, if4.preempt};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL vec%0d outputs: got st=%0d gnt0=%b gnt=%b valid=%b id=%0d pre=%b, want st=%0d gnt0=%b gnt=%b valid=%b id=%0d pre=%b",
                     idx, got[13:12], got[11:8], got[7:4], got[3], got[2:1], got[0],
                     exp[13:12], exp[11:8], exp[7:4], exp[3], exp[2:1], exp[0]);
        end
        total++;
        if ($countones(if4.gnt) > 1 || if4.gnt_valid !== (|if4.gnt)) begin
            bad++;
            $display("FAIL vec%0d onehot/valid: got gnt=%b valid=%b, want popcount<=1 and valid=|gnt",
                     idx, if4.gnt, if4.gnt_valid);
        end
        total++;
        if ((if4.gnt & ~e.req) !== 4'b0000) begin
            bad++;
            $display("FAIL vec%0d gnt_without_req: got gnt=%b with prior req=%b, want gnt subset of req",
                     idx, if4.gnt, e.req);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        if4.req = '0;
        if0.req = '0;

        // single requester, release returns to idle
        do_reset();
        for (int i = 0; i < 4; i++) v(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, SG);
        v(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, SR);
        v(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, SI);

        // all requesting, each owner holds 3 cycles: order 0,1,2,3,0
        do_reset();
        for (int k = 0; k < N; k++) begin
            for (int c = 0; c < 3; c++) v(1'b1, 4'b1111, onehot(k), IDW'(k), 1'b0, SG);
            v(1'b1, 4'b1111 & ~onehot(k), 4'b0000, IDW'(k), 1'b0, SR);
        end
        v(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0, SG);
        v(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, SR);
        v(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, SI);

        // ptr=2 after owner 1, req=1001 -> 3 then 0
        do_reset();
        v(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, SG);
        v(1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, SR);
        v(1'b1, 4'b1001, 4'b1000, 2'd3, 1'b0, SG);
        v(1'b1, 4'b1001, 4'b1000, 2'd3, 1'b0, SG);
        v(1'b1, 4'b0001, 4'b0000, 2'd3, 1'b0, SR);
        v(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, SG);
        v(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, SR);
        v(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, SI);

        // preemption ping-pong between 1 and 2; unlimited instance keeps owner 1
        do_reset();
        vd(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, SG, 4'b0010);
        for (int c = 0; c < 3; c++) vd(1'b1, 4'b0110, 4'b0010, 2'd1, 1'b0, SG, 4'b0010);
        vd(1'b1, 4'b0110, 4'b0000, 2'd1, 1'b1, SR, 4'b0010);
        for (int c = 0; c < 4; c++) vd(1'b1, 4'b0110, 4'b0100, 2'd2, 1'b0, SG, 4'b0010);
        vd(1'b1, 4'b0110, 4'b0000, 2'd2, 1'b1, SR, 4'b0010);
        vd(1'b1, 4'b0110, 4'b0010, 2'd1, 1'b0, SG, 4'b0010);
        vd(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, SG, 4'b0010);
        vd(1'b1, 4'b0110, 4'b0010, 2'd1, 1'b0, SG, 4'b0010);
        vd(1'b1, 4'b0110, 4'b0010, 2'd1, 1'b0, SG, 4'b0010);
        // owner drop coincides with the hold limit: plain release, no preempt
        vd(1'b1, 4'b0100, 4'b0000, 2'd1, 1'b0, SR, 4'b0000);
        vd(1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, SI, 4'b0000);

        // lone requester is never preempted
        do_reset();
        for (int c = 0; c < 20; c++) v(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0, SG);
        v(1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0, SR);
        v(1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0, SI);

        // reset mid-grant, then ptr=0 priority; then a 1-cycle req pulse
        do_reset();
        v(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, SG);
        v(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, SG);
        v(1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, SI);
        v(1'b1, 4'b0110, 4'b0010, 2'd1, 1'b0, SG);
        v(1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, SR);
        v(1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, SI);
        v(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, SG);
        v(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, SR);
        v(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, SI);

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_rr_arbiter.md
Name: sync_rr_arbiter

Overview:
- Clocked round-robin arbiter that shares one resource between N requesters.
- Each requester uses a 4-phase req/gnt handshake: raise req, wait for gnt, keep req high while using the resource, drop req to release it.
- This is the synchronous counterpart to the async mutual-exclusion tree arbiter cells. It is used where requesters live in the clk domain.
- Grants are one-hot, registered and never overlap. An optional hold limit preempts a long-running owner.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 0, maximum grant length in cycles when other requests are pending; 0 = unlimited (no preemption).
- IDW, $clog2(N), width of gnt_id.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  N  request per requester; req[i] must be held high until gnt[i] is seen.
- gnt  output  N  one-hot grant, registered.
- gnt_valid  output  1  OR of gnt, registered.
- gnt_id  output  IDW  index of the current owner; holds its last value when gnt_valid=0.
- preempt  output  1  one-cycle pulse in the cycle gnt drops because of the MAX_HOLD limit.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - gnt=0, gnt_valid=0, gnt_id=0, preempt=0.
  - ptr=0, so req[0] has highest priority after reset.
  - hold_cnt=0, state=IDLE.
  - Reset mid-grant drops gnt on that same edge. There is no release cycle.
- States:
  - IDLE: no owner.
  - GRANT: an owner exists.
  - RELEASE: a one-cycle return-to-zero gap with gnt=0.
- Selection rule: winner = first i with req[i]=1, scanning circularly from ptr, i.e. ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- IDLE:
  - If req!=0: register gnt=onehot(winner), gnt_id=winner, hold_cnt=0, go to GRANT.
  - Latency: req sampled high at edge t gives gnt high after edge t.
  - Otherwise stay in IDLE.
- GRANT (owner k):
  - Hold condition: while req[k]=1 and no preemption, gnt stays stable and hold_cnt increments (saturating at MAX_HOLD).
  - req[k]=0 sampled: gnt=0, ptr=(k+1) mod N, go to RELEASE.
  - Preemption:
    - Condition: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and (req & ~onehot(k))!=0.
    - Action: gnt=0, preempt=1 for one cycle, ptr=(k+1) mod N, go to RELEASE.
  - No preemption when no other request is pending. The owner keeps the grant indefinitely.
  - Requests from other requesters in this state are only recorded by the scan at the next arbitration. req is not latched.
- RELEASE:
  - gnt=0 for exactly this one cycle, so there is never overlap between owners.
  - Arbitrate with the updated ptr.
    - If req!=0: go to GRANT with the new winner.
    - Otherwise go to IDLE.
  - A preempted owner that still holds req is treated as a fresh request. It has the lowest priority because ptr has advanced past it.
  - If it is the only requester, it is re-granted after the one-cycle gap.
- Simultaneous events:
  - req[k] drop coincides with the preemption condition: treat as a normal release. preempt=0.
  - Several requests arrive in the same cycle: only the selection rule decides the winner.
- Requester protocol violations:
  - A req pulse that drops before gnt is not an error. If the pulse is still high when sampled for arbitration, the grant lasts 1 cycle followed by RELEASE.
- Invariants (assert in bench):
  - popcount(gnt)<=1.
  - gnt[i] implies req[i] was high on the previous edge.
  - gnt_valid == |gnt.

Test Plan:
- Reset, then req=4'b0001 at edge 1 → gnt=4'b0001 after edge 1, gnt_id=0. req drops at edge 5 → gnt=0 after edge 5, state returns to IDLE.
- req=4'b1111 held continuously, each owner drops req 3 cycles after its grant → grant order 0,1,2,3,0, with exactly one gnt=0 cycle between owners.
- ptr=2 after owner 1 releases, req=4'b1001 → grant goes to 3, then 0.
- MAX_HOLD=4, req[1] held high forever, req[2] raised at grant cycle 1:
  - gnt[1] lasts 4 cycles, then preempt=1 for 1 cycle, then gnt[2].
  - After 4 cycles with req[2] still high, preempt again and gnt returns to 1.
- MAX_HOLD=4, only req[3] high for 20 cycles → gnt[3] stays continuous and preempt never pulses.
- rst_n=0 during GRANT of requester 2 → gnt=0 after that edge. After reset, req=4'b0110 → gnt[1] wins because ptr=0.
